// File: rtl/gpio_pkg.sv
// Shared GPIO register-map package.
// Used by both the input-capture block and the output block so the
// two blocks agree on bus width and register addresses.
package gpio_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_PIN     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN  = 3'd4;

endpackage

// File: rtl/gpio_in_sync_filter.sv
// Single-pin input conditioning: 2-flop synchronizer, glitch filter and
// rise/fall edge pulses.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   pin_async  raw external pin
//   filt       filtered pin level
//   rise/fall  1-cycle pulses, high in the cycle whose closing edge
//              updates filt (so a status register loading them sets on
//              the same edge as filt changes)
module gpio_in_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_async,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // s2 has disagreed with filt for FILTER_LEN consecutive edges,
  // counting this one.
  assign accept = (s2 != filt) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      s1 <= pin_async;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (accept) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = accept & s2;
  assign fall = accept & ~s2;

endmodule

// File: rtl/gpio_in_capture.sv
// Input-direction GPIO block. Each pin is synchronized and glitch
// filtered; enabled edges set sticky STATUS bits which drive a level irq.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   we, re, addr        register bus strobes and register select
//   data_in / data_out  write data / registered read data
//   rvalid              1-cycle pulse marking a read result on data_out
//   gpio_in             asynchronous external pins
//   irq                 |(STATUS & IRQ_EN)
module gpio_in_capture
  import gpio_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic              irq
);

  logic [WIDTH-1:0]  filt;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  fall;
  logic [WIDTH-1:0]  status;
  logic [WIDTH-1:0]  rise_en;
  logic [WIDTH-1:0]  fall_en;
  logic [WIDTH-1:0]  irq_en;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  set_bits;
  logic [WIDTH-1:0]  clr_bits;
  logic [DATA_W-1:0] rd_data;
  logic              unused_data_hi;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_in_sync_filter #(
      .FILTER_LEN (FILTER_LEN)
    ) u_filter (
      .clk       (clk),
      .reset     (reset),
      .pin_async (gpio_in[i]),
      .filt      (filt[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  // Only the low WIDTH bits of a write land in a register.
  assign wr_data        = data_in[WIDTH-1:0];
  assign unused_data_hi = ^data_in;

  assign set_bits = (rise & rise_en) | (fall & fall_en);
  assign clr_bits = (we && addr == ADDR_STATUS) ? wr_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq_en  <= '0;
    end else begin
      // A new edge wins over a simultaneous write-1-to-clear.
      status <= (status & ~clr_bits) | set_bits;
      if (we) begin
        case (addr)
          ADDR_RISE_EN: rise_en <= wr_data;
          ADDR_FALL_EN: fall_en <= wr_data;
          ADDR_IRQ_EN:  irq_en  <= wr_data;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_PIN:     rd_data[WIDTH-1:0] = filt;
      ADDR_STATUS:  rd_data[WIDTH-1:0] = status;
      ADDR_RISE_EN: rd_data[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN: rd_data[WIDTH-1:0] = fall_en;
      ADDR_IRQ_EN:  rd_data[WIDTH-1:0] = irq_en;
      default:      ;
    endcase
  end

  // Read data is taken from pre-write flops, so a same-cycle write is
  // not visible until the following read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rvalid   <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        data_out <= rd_data;
      end
    end
  end

  assign irq = |(status & irq_en);

endmodule

// File: tb/tb_gpio_in_capture.sv
// Self-checking bench for gpio_in_capture: directed scenarios followed by
// randomized pins and bus traffic, every cycle compared to a reference model.
module tb_gpio_in_capture;
  import gpio_pkg::*;

  localparam int W = 8;
  localparam int F = 4;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        we      = 1'b0;
  logic        re      = 1'b0;
  logic [2:0]  addr    = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rvalid;
  logic        irq;
  logic [W-1:0] gpio_in = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_filt, m_status, m_rise_en, m_fall_en, m_irq_en;
  logic [31:0]  m_dout;
  logic         m_rvalid;
  logic [W-1:0] hist [0:F];   // hist[k]: gpio_in seen k+1 edges ago

  gpio_in_capture #(.WIDTH(W), .FILTER_LEN(F)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .re       (re),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rvalid   (rvalid),
    .gpio_in  (gpio_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_filt = '0; m_status = '0; m_rise_en = '0; m_fall_en = '0; m_irq_en = '0;
    m_dout = '0; m_rvalid = 1'b0;
    for (int k = 0; k <= F; k++) hist[k] = '0;
  endtask

  function automatic logic [31:0] reg_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_filt);
      3'd1:    return 32'(m_status);
      3'd2:    return 32'(m_rise_en);
      3'd3:    return 32'(m_fall_en);
      3'd4:    return 32'(m_irq_en);
      default: return 32'd0;
    endcase
  endfunction

  // A pin's filtered value flips once the synchronized pin has shown the
  // opposite level for F consecutive edges (pin seen 2..F+1 edges ago).
  task automatic model_edge();
    logic [W-1:0] nf, setv, clrv;
    bit steady;
    if (!reset) begin
      model_clear();
      return;
    end
    if (re) begin
      m_dout   = reg_read(addr);
      m_rvalid = 1'b1;
    end else begin
      m_rvalid = 1'b0;
    end
    nf = m_filt;
    for (int i = 0; i < W; i++) begin
      steady = 1'b1;
      for (int k = 1; k <= F; k++) if (hist[k][i] == m_filt[i]) steady = 1'b0;
      if (steady) nf[i] = ~m_filt[i];
    end
    setv = (nf & ~m_filt & m_rise_en) | (~nf & m_filt & m_fall_en);
    clrv = (we && addr == 3'd1) ? data_in[W-1:0] : '0;
    if (we) begin
      case (addr)
        3'd2:    m_rise_en = data_in[W-1:0];
        3'd3:    m_fall_en = data_in[W-1:0];
        3'd4:    m_irq_en  = data_in[W-1:0];
        default: ;
      endcase
    end
    m_status = (m_status & ~clrv) | setv;
    m_filt   = nf;
    for (int k = F; k >= 1; k--) hist[k] = hist[k-1];
    hist[0] = gpio_in;
  endtask

  task automatic check_outputs();
    chk("data_out", data_out, m_dout);
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("irq", 32'(irq), 32'(|(m_status & m_irq_en)));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; data_in = d;
    tick();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    tick();
    re = 1'b0;
    d = data_out;
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_outputs();
    chk("rst_async_dout", data_out, 32'd0);
    ticks(3);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int idx;
    model_clear();

    // 1 reset with toggling pins
    for (int i = 0; i < 5; i++) begin
      gpio_in = W'($urandom());
      re = 1'b1; addr = 3'd0;
      tick();
    end
    re = 1'b0;
    chk("rst_dout", data_out, 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    gpio_in = '0;
    reset = 1'b1;
    ticks(6);
    bus_read(3'd1, rd);
    chk("rst_status", rd, 32'd0);

    // 2 glitch filter and latency
    gpio_in = 8'h01;
    ticks(3);
    gpio_in = 8'h00;
    ticks(8);
    bus_read(3'd0, rd);
    chk("glitch_pin", rd, 32'd0);
    gpio_in = 8'h01;
    re = 1'b1; addr = 3'd0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      chk("latency_pin", data_out, (j <= 6) ? 32'd0 : 32'd1);
    end
    re = 1'b0;
    ticks(3);
    bus_read(3'd0, rd);
    chk("held_pin", rd, 32'h01);

    // 3 rise edge and irq
    gpio_in = 8'h00;
    ticks(8);
    bus_write(3'd2, 32'h0F);
    bus_write(3'd4, 32'h01);
    gpio_in = 8'h81;
    ticks(8);
    chk("rise_irq", 32'(irq), 32'd1);
    bus_read(3'd1, rd);
    chk("rise_status", rd, 32'h01);
    bus_write(3'd1, 32'h01);
    chk("w1c_irq", 32'(irq), 32'd0);
    bus_read(3'd1, rd);
    chk("w1c_status", rd, 32'h00);

    // 4 fall edge, masked irq
    bus_write(3'd3, 32'h80);
    gpio_in = 8'h01;
    ticks(8);
    bus_read(3'd1, rd);
    chk("fall_status", rd, 32'h80);
    chk("fall_irq", 32'(irq), 32'd0);
    bus_write(3'd1, 32'hFF);

    // 5 W1C colliding with a rise on the same bit
    gpio_in = 8'h00;
    ticks(8);
    gpio_in = 8'h01;
    ticks(5);
    bus_write(3'd1, 32'h01);
    bus_read(3'd1, rd);
    chk("collide_status", rd, 32'h01);
    chk("collide_irq", 32'(irq), 32'd1);
    bus_write(3'd1, 32'hFF);

    // 6 bus corner cases
    we = 1'b1; re = 1'b1; addr = 3'd2; data_in = 32'hAB;
    tick();
    we = 1'b0; re = 1'b0;
    chk("wr_rd_dout", data_out, 32'h0F);
    chk("wr_rd_rvalid", 32'(rvalid), 32'd1);
    tick();
    chk("rvalid_drop", 32'(rvalid), 32'd0);
    chk("dout_hold", data_out, 32'h0F);
    bus_read(3'd2, rd);
    chk("reread", rd, 32'hAB);
    bus_write(3'd3, 32'hFFFF_FF0F);
    bus_read(3'd3, rd);
    chk("upper_ignored", rd, 32'h0F);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, rd);
    chk("addr5", rd, 32'd0);
    bus_read(3'd6, rd);
    chk("addr6", rd, 32'd0);

    // randomized traffic with a mid-run asynchronous reset
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, W - 1);
        gpio_in[idx] = ~gpio_in[idx];
      end
      we      = ($urandom_range(0, 4) == 0);
      re      = ($urandom_range(0, 1) == 0);
      addr    = 3'($urandom_range(0, 7));
      data_in = $urandom();
      if (c == 700) begin
        re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        async_reset();
      end
      tick();
    end
    we = 1'b0; re = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
